// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a_i - b_i), LSB first, with start/busy/done handshake.
// Optional signed-overflow output ovf_o is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] r_q, r_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_shift;
`ifdef SERIAL_SUB_OVF_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell and the result word as it would look after this bit lands
    assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
    assign r_shift = {d_bit, r_q};

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    amsb_d  = a_i[WIDTH-1];
                    bmsb_d  = b_i[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = r_shift[WIDTH-1:1];
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    diff_d  = r_shift;
                    bout_d  = br_next;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (amsb_q != bmsb_q) && (d_bit != amsb_q);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); checks ovf_o when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       start_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] diff_o;
    logic       bout_o;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf_o;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_diff = 8'h00;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .diff_o  (diff_o),
        .bout_o  (bout_o)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation; glitch >= 0 re-asserts start_i (with 1-2) at that RUN sample
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int glitch,
                          input logic [7:0] exp_d, input logic exp_b, input logic exp_v);
        int cyc;
        int busy_n;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        cyc     = 0;
        busy_n  = 0;
        while (!done_o && cyc < 40) begin
            if (cyc == 4) check("held_mid_run", 32'(diff_o), 32'(last_diff));
            if (busy_o) busy_n++;
            start_i = (cyc == glitch);
            if (cyc == glitch) begin
                a_i = 8'd1;
                b_i = 8'd2;
            end
            step();
            cyc++;
        end
        start_i = 1'b0;
        check("latency", 32'(cyc), 32'd8);
        check("busy_cycles", 32'(busy_n), 32'd8);
        check("done", 32'(done_o), 32'd1);
        check("busy_in_done", 32'(busy_o), 32'd0);
        check("diff", 32'(diff_o), 32'(exp_d));
        check("bout", 32'(bout_o), 32'(exp_b));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf_o), 32'(exp_v));
`else
        if (exp_v) begin end
`endif
        last_diff = exp_d;
    endtask

    initial begin
        logic done_seen;
        rstn_i  = 1'b0;
        start_i = 1'b0;
        a_i     = 8'h00;
        b_i     = 8'h00;
        repeat (2) step();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_diff", 32'(diff_o), 32'd0);
        check("rst_bout", 32'(bout_o), 32'd0);
        rstn_i = 1'b1;
        step();

        // Basic vectors
        run_op(8'd100, 8'd58, -1, 8'd42, 1'b0, 1'b0);
        step();
        check("done_pulse_ends", 32'(done_o), 32'd0);
        run_op(8'd5, 8'd9, -1, 8'hFC, 1'b1, 1'b0);
        step();
        run_op(8'd0, 8'd0, -1, 8'h00, 1'b0, 1'b0);
        step();
        run_op(8'hFF, 8'h01, -1, 8'hFE, 1'b0, 1'b0);
        step();
        run_op(8'h80, 8'h01, -1, 8'h7F, 1'b0, 1'b1);
        step();
        run_op(8'h05, 8'h03, -1, 8'h02, 1'b0, 1'b0);
        step();
        run_op(8'h7F, 8'hFF, -1, 8'h80, 1'b1, 1'b1);
        step();

        // start_i during RUN is ignored
        run_op(8'd100, 8'd58, 2, 8'd42, 1'b0, 1'b0);
        step();
        check("idle_after_glitch", 32'(busy_o), 32'd0);

        // Back-to-back: second start accepted in the DONE cycle
        run_op(8'd7, 8'd3, -1, 8'd4, 1'b0, 1'b0);
        run_op(8'd3, 8'd7, -1, 8'hFC, 1'b1, 1'b0);

        // Reset mid-RUN
        a_i     = 8'd100;
        b_i     = 8'd58;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (3) step();
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_diff", 32'(diff_o), 32'd0);
        check("midrst_bout", 32'(bout_o), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("midrst_ovf", 32'(ovf_o), 32'd0);
`endif
        repeat (2) step();
        rstn_i    = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin
            step();
            done_seen = done_seen | done_o;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        last_diff = 8'h00;
        run_op(8'd9, 8'd9, -1, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
